// File: rtl/rgen_apb_pkg.sv
// Shared types and constants for the APB bridge master.
//   rgen_state_e : bridge FSM states
//   RGEN_STATUS_*: encodings of the o_status response field
package rgen_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_RESPONSE = 2'd3
  } rgen_state_e;

  localparam logic [1:0] RGEN_STATUS_OKAY    = 2'b00;
  localparam logic [1:0] RGEN_STATUS_SLVERR  = 2'b01;
  localparam logic [1:0] RGEN_STATUS_TIMEOUT = 2'b10;

endpackage

// File: rtl/rgen_apb_timeout_counter.sv
// Watchdog for the ACCESS phase: counts stalled cycles and flags when the
// count reaches TIMEOUT_CYCLES-1.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero the count (asserted the cycle before ACCESS)
//   count_en_i   : one stalled ACCESS cycle
//   expired_o    : registered, high while the count equals TIMEOUT_CYCLES-1
module rgen_apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // expired_q mirrors (cnt_q == CNT_LAST) so the flag is available registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (count_en_i && !expired_q) begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == CNT_LAST);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/rgen_apb_bridge_master.sv
// Local command to APB master bridge: one transfer per command through
// IDLE -> SETUP -> ACCESS -> RESPONSE, with registered APB and response outputs.
// Optional ACCESS watchdog enabled by defining RGEN_APB_BRIDGE_TIMEOUT_EN.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   i_command_valid/i_write/i_read     : local request (write wins if both set)
//   i_address/i_write_data/i_write_mask: local command payload
//   o_response_ready                   : one-cycle completion pulse
//   o_read_data, o_status              : result, held until the next response
//   o_paddr..o_pstrb, i_pready..       : APB master interface
module rgen_apb_bridge_master
  import rgen_apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned LOCAL_ADDRESS_WIDTH = 16,
  parameter int unsigned APB_ADDRESS_WIDTH   = 16,
  parameter logic [2:0]  PPROT_VALUE         = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES      = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_command_valid,
  input  logic                           i_write,
  input  logic                           i_read,
  input  logic [LOCAL_ADDRESS_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0]          i_write_data,
  input  logic [DATA_WIDTH-1:0]          i_write_mask,
  output logic                           o_response_ready,
  output logic [DATA_WIDTH-1:0]          o_read_data,
  output logic [1:0]                     o_status,
  output logic [APB_ADDRESS_WIDTH-1:0]   o_paddr,
  output logic [2:0]                     o_pprot,
  output logic                           o_psel,
  output logic                           o_penable,
  output logic                           o_pwrite,
  output logic [DATA_WIDTH-1:0]          o_pwdata,
  output logic [DATA_WIDTH/8-1:0]        o_pstrb,
  input  logic                           i_pready,
  input  logic [DATA_WIDTH-1:0]          i_prdata,
  input  logic                           i_pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  rgen_state_e              state_q;
  logic                     psel_q;
  logic                     penable_q;
  logic                     pwrite_q;
  logic                     resp_q;
  logic [APB_ADDRESS_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0]    pwdata_q;
  logic [STRB_W-1:0]        pstrb_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [1:0]               status_q;

  logic [STRB_W-1:0]        strb_c;
  logic                     accept_c;
  logic                     timeout_c;

  // A byte lane is strobed if any bit of its mask byte is set
  always_comb begin
    strb_c = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_c[i] = |i_write_mask[8*i +: 8];
    end
  end

  assign accept_c = i_command_valid && (i_write || i_read);

`ifdef RGEN_APB_BRIDGE_TIMEOUT_EN
  rgen_apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_q == ST_SETUP),
    .count_en_i ((state_q == ST_ACCESS) && !i_pready),
    .expired_o  (timeout_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 32'd1);
  assign timeout_c          = 1'b0;
`endif

  // Bridge FSM with all APB/response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      resp_q    <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      status_q  <= RGEN_STATUS_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_q <= 1'b0;
          if (accept_c) begin
            paddr_q   <= APB_ADDRESS_WIDTH'(i_address);
            pwrite_q  <= i_write;
            pwdata_q  <= i_write_data;
            pstrb_q   <= i_write ? strb_c : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            resp_q    <= 1'b1;
            rdata_q   <= pwrite_q ? '0 : i_prdata;
            status_q  <= {1'b0, i_pslverr};
            state_q   <= ST_RESPONSE;
          end else if (timeout_c) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            resp_q    <= 1'b1;
            rdata_q   <= '0;
            status_q  <= RGEN_STATUS_TIMEOUT;
            state_q   <= ST_RESPONSE;
          end
        end
        ST_RESPONSE: begin
          resp_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_response_ready = resp_q;
  assign o_read_data      = rdata_q;
  assign o_status         = status_q;
  assign o_paddr          = paddr_q;
  assign o_pprot          = PPROT_VALUE;
  assign o_psel           = psel_q;
  assign o_penable        = penable_q;
  assign o_pwrite         = pwrite_q;
  assign o_pwdata         = pwdata_q;
  assign o_pstrb          = pstrb_q;

endmodule

// File: tb/tb_rgen_apb_bridge_master.sv
// Directed bench for rgen_apb_bridge_master (32-bit data, 16-bit addresses,
// PPROT 3'b010, TIMEOUT_CYCLES 4). Timeout behaviour follows
// RGEN_APB_BRIDGE_TIMEOUT_EN as seen by this compilation.
module tb_rgen_apb_bridge_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_command_valid;
  logic        i_write;
  logic        i_read;
  logic [15:0] i_address;
  logic [31:0] i_write_data;
  logic [31:0] i_write_mask;
  logic        o_response_ready;
  logic [31:0] o_read_data;
  logic [1:0]  o_status;
  logic [15:0] o_paddr;
  logic [2:0]  o_pprot;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready;
  logic [31:0] i_prdata;
  logic        i_pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  rgen_apb_bridge_master #(
    .DATA_WIDTH          (32),
    .LOCAL_ADDRESS_WIDTH (16),
    .APB_ADDRESS_WIDTH   (16),
    .PPROT_VALUE         (3'b010),
    .TIMEOUT_CYCLES      (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .i_write          (i_write),
    .i_read           (i_read),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_write_mask     (i_write_mask),
    .o_response_ready (o_response_ready),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command now (cycle 0) and follow it to the response cycle.
  task automatic do_xfer(input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask,
                         input int waits, input logic [31:0] prdata, input logic slverr,
                         input logic exp_pwrite, input logic [3:0] exp_strb,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_status);
    i_command_valid = 1'b1;
    i_write         = wr;
    i_read          = rd;
    i_address       = addr;
    i_write_data    = wdata;
    i_write_mask    = mask;
    i_pready        = 1'b0;
    i_prdata        = 32'hFFFF_FFFF;
    i_pslverr       = 1'b0;
    step();
    check("setup_psel",    64'(o_psel), 64'd1);
    check("setup_penable", 64'(o_penable), 64'd0);
    check("setup_paddr",   64'(o_paddr), 64'(addr));
    check("setup_pwrite",  64'(o_pwrite), 64'(exp_pwrite));
    check("setup_pstrb",   64'(o_pstrb), 64'(exp_strb));
    check("setup_pwdata",  64'(o_pwdata), 64'(wdata));
    step();
    for (int w = 0; w < waits; w++) begin
      check("wait_psel",    64'(o_psel), 64'd1);
      check("wait_penable", 64'(o_penable), 64'd1);
      check("wait_paddr",   64'(o_paddr), 64'(addr));
      check("wait_pwrite",  64'(o_pwrite), 64'(exp_pwrite));
      check("wait_pstrb",   64'(o_pstrb), 64'(exp_strb));
      check("wait_pwdata",  64'(o_pwdata), 64'(wdata));
      check("wait_resp",    64'(o_response_ready), 64'd0);
      step();
    end
    check("access_penable", 64'(o_penable), 64'd1);
    check("access_resp",    64'(o_response_ready), 64'd0);
    i_pready  = 1'b1;
    i_prdata  = prdata;
    i_pslverr = slverr;
    step();
    check("resp_pulse",   64'(o_response_ready), 64'd1);
    check("resp_psel",    64'(o_psel), 64'd0);
    check("resp_penable", 64'(o_penable), 64'd0);
    check("resp_rdata",   64'(o_read_data), 64'(exp_rdata));
    check("resp_status",  64'(o_status), 64'(exp_status));
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
  endtask

  task automatic go_idle();
    step();
    i_command_valid = 1'b0;
    i_write         = 1'b0;
    i_read          = 1'b0;
    check("post_resp_low", 64'(o_response_ready), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    i_command_valid = 1'b0;
    i_write         = 1'b0;
    i_read          = 1'b0;
    i_address       = '0;
    i_write_data    = '0;
    i_write_mask    = '0;
    i_pready        = 1'b0;
    i_prdata        = '0;
    i_pslverr       = 1'b0;

    #12;
    check("rst_psel",   64'(o_psel), 64'd0);
    check("rst_pen",    64'(o_penable), 64'd0);
    check("rst_resp",   64'(o_response_ready), 64'd0);
    check("rst_paddr",  64'(o_paddr), 64'd0);
    check("rst_rdata",  64'(o_read_data), 64'd0);
    check("rst_status", 64'(o_status), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("pprot", 64'(o_pprot), 64'h2);

    // Write straight out of reset, zero wait states
    do_xfer(1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'h00FF_00FF, 0, 32'h0, 1'b0,
            1'b1, 4'b0101, 32'h0, 2'b00);
    go_idle();

    // Read with three wait states
    do_xfer(1'b0, 1'b1, 16'h0004, 32'h1111_2222, 32'hFFFF_FFFF, 3, 32'h1234_5678, 1'b0,
            1'b0, 4'b0000, 32'h1234_5678, 2'b00);
    go_idle();

    // Valid with neither write nor read is not accepted; read data holds
    i_command_valid = 1'b1;
    step();
    step();
    check("noop_psel",  64'(o_psel), 64'd0);
    check("hold_rdata", 64'(o_read_data), 64'h1234_5678);
    i_command_valid = 1'b0;
    step();

    // Slave error read, then back-to-back write+read (treated as write)
    do_xfer(1'b0, 1'b1, 16'h0008, 32'h0, 32'h0, 1, 32'hCAFE_F00D, 1'b1,
            1'b0, 4'b0000, 32'hCAFE_F00D, 2'b01);
    step();
    do_xfer(1'b1, 1'b1, 16'h00FC, 32'h0BAD_C0DE, 32'h8000_0100, 0, 32'h5555_5555, 1'b0,
            1'b1, 4'b1010, 32'h0, 2'b00);
    go_idle();

    // Read leaving nonzero data behind
    do_xfer(1'b0, 1'b1, 16'h0014, 32'h0, 32'h0, 0, 32'h5A5A_0001, 1'b0,
            1'b0, 4'b0000, 32'h5A5A_0001, 2'b00);
    go_idle();

    // Stalled ACCESS
    i_command_valid = 1'b1;
    i_read          = 1'b1;
    i_address       = 16'h0020;
    i_pready        = 1'b0;
    step();
    check("stall_setup", 64'(o_psel), 64'd1);
    step();
`ifdef RGEN_APB_BRIDGE_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      check("to_wait_resp",  64'(o_response_ready), 64'd0);
      check("to_wait_pen",   64'(o_penable), 64'd1);
      check("to_wait_rdata", 64'(o_read_data), 64'h5A5A_0001);
      step();
    end
    check("to_resp",   64'(o_response_ready), 64'd1);
    check("to_status", 64'(o_status), 64'h2);
    check("to_rdata",  64'(o_read_data), 64'd0);
    check("to_psel",   64'(o_psel), 64'd0);
    go_idle();
`else
    for (int k = 0; k < 30; k++) begin
      check("stall_resp", 64'(o_response_ready), 64'd0);
      check("stall_pen",  64'(o_penable), 64'd1);
      step();
    end
    i_pready = 1'b1;
    i_prdata = 32'h0000_0077;
    step();
    check("stall_done",   64'(o_response_ready), 64'd1);
    check("stall_status", 64'(o_status), 64'd0);
    check("stall_rdata",  64'(o_read_data), 64'h77);
    i_pready = 1'b0;
    go_idle();
`endif

    // Reset pulse in the middle of ACCESS
    i_command_valid = 1'b1;
    i_read          = 1'b1;
    i_address       = 16'h0030;
    step();
    step();
    check("pre_rst_pen", 64'(o_penable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel",   64'(o_psel), 64'd0);
    check("mid_rst_pen",    64'(o_penable), 64'd0);
    check("mid_rst_resp",   64'(o_response_ready), 64'd0);
    check("mid_rst_paddr",  64'(o_paddr), 64'd0);
    check("mid_rst_rdata",  64'(o_read_data), 64'd0);
    check("mid_rst_status", 64'(o_status), 64'd0);
    i_command_valid = 1'b0;
    i_read          = 1'b0;
    i_pready        = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_rst_resp", 64'(o_response_ready), 64'd0);
      check("post_rst_psel", 64'(o_psel), 64'd0);
    end

    // Recovery write with two wait states
    do_xfer(1'b1, 1'b0, 16'h0040, 32'hA5A5_5A5A, 32'h0000_FF00, 2, 32'h0, 1'b0,
            1'b1, 4'b0010, 32'h0, 2'b00);
    go_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
